// File: rtl/mul_pkg.sv
// Shared widths and types for the 4x4 multiplier datapath.
package mul_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/fa.sv
// Gate-level full-adder cell: compresses three bits of equal weight into sum and carry.
module fa (
    output logic Cout,
    output logic S,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, A, B);
    xor g_x1 (S, ab_x, Cin);
    and g_a0 (ab_a, A, B);
    and g_a1 (cx_a, ab_x, Cin);
    or  g_o0 (Cout, ab_a, cx_a);

endmodule

// File: rtl/ha.sv
// Half-adder cell: two inputs of equal weight give sum and carry.
module ha (
    output logic Cout,
    output logic S,
    input  logic A,
    input  logic B
);

    assign S    = A ^ B;
    assign Cout = A & B;

endmodule

// File: rtl/wallace_mul4_pipe.sv
// Three-stage 4x4 unsigned multiplier: operand register, two-level Wallace
// reduction into sum/carry rows, then an 8-bit ripple adder into the output.
module wallace_mul4_pipe
    import mul_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  op_t   a,
    input  op_t   b,
    output logic  out_valid,
    input  logic  out_ready,
    output prod_t p
);

    logic  v0, v1, v2;
    op_t   a_q, b_q;
    prod_t sum_q, carry_q;
    logic  en;

    // The whole pipe moves as one; only a stalled, full output slot stops it.
    assign en        = !v2 || out_ready;
    assign in_ready  = en;
    assign out_valid = v2;

    logic [OP_W-1:0][OP_W-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                pp[i][j] = a_q[i] & b_q[j];
            end
        end
    end

    // Level 1: column heights 1,2,3,4,3,2,1 drop to at most 3 (only weight 3).
    logic l1_s1, l1_c1, l1_s2, l1_c2, l1_s3, l1_c3;
    logic l1_s4, l1_c4, l1_s5, l1_c5;

    ha u_l1_w1 (.Cout(l1_c1), .S(l1_s1), .A(pp[0][1]), .B(pp[1][0]));
    fa u_l1_w2 (.Cout(l1_c2), .S(l1_s2), .A(pp[0][2]), .B(pp[1][1]), .Cin(pp[2][0]));
    fa u_l1_w3 (.Cout(l1_c3), .S(l1_s3), .A(pp[0][3]), .B(pp[1][2]), .Cin(pp[2][1]));
    fa u_l1_w4 (.Cout(l1_c4), .S(l1_s4), .A(pp[1][3]), .B(pp[2][2]), .Cin(pp[3][1]));
    ha u_l1_w5 (.Cout(l1_c5), .S(l1_s5), .A(pp[2][3]), .B(pp[3][2]));

    // Level 2: weight 3 needs an FA, and weights 4..6 each take a HA so the
    // carry rippling in from below still leaves at most two bits per column.
    logic l2_s3, l2_c3, l2_s4, l2_c4, l2_s5, l2_c5, l2_s6, l2_c6;

    fa u_l2_w3 (.Cout(l2_c3), .S(l2_s3), .A(l1_s3), .B(pp[3][0]), .Cin(l1_c2));
    ha u_l2_w4 (.Cout(l2_c4), .S(l2_s4), .A(l1_s4), .B(l1_c3));
    ha u_l2_w5 (.Cout(l2_c5), .S(l2_s5), .A(l1_s5), .B(l1_c4));
    ha u_l2_w6 (.Cout(l2_c6), .S(l2_s6), .A(pp[3][3]), .B(l1_c5));

    prod_t sum_row;
    prod_t carry_row;

    assign sum_row   = {1'b0, l2_s6, l2_s5, l2_s4, l2_s3, l1_s2, l1_s1, pp[0][0]};
    assign carry_row = {l2_c6, l2_c5, l2_c4, l2_c3, 1'b0, l1_c1, 2'b00};

    // Final ripple adder; each stage owns its carry so the chain is not one
    // self-referencing vector.
    prod_t cpa_sum;
    logic  cpa_cout_unused;

    for (genvar k = 0; k < PROD_W - 1; k++) begin : g_cpa
        logic c;
        if (k == 0) begin : g_lsb
            ha u_ha (.Cout(c), .S(cpa_sum[k]), .A(sum_q[k]), .B(carry_q[k]));
        end else begin : g_mid
            fa u_fa (.Cout(c), .S(cpa_sum[k]), .A(sum_q[k]), .B(carry_q[k]),
                     .Cin(g_cpa[k-1].c));
        end
    end

    // The product never exceeds 225, so the top carry is always 0.
    fa u_cpa_msb (.Cout(cpa_cout_unused), .S(cpa_sum[PROD_W-1]),
                  .A(sum_q[PROD_W-1]), .B(carry_q[PROD_W-1]),
                  .Cin(g_cpa[PROD_W-2].c));

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's pre-edge value and the pipe shifts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so p reads 0 until the first result.
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            p       <= '0;
        end else if (en) begin
            v0      <= in_valid;
            a_q     <= a;
            b_q     <= b;
            v1      <= v0;
            sum_q   <= sum_row;
            carry_q <= carry_row;
            v2      <= v1;
            p       <= cpa_sum;
        end
    end

endmodule

// File: tb/tb_wallace_mul4_pipe.sv
// Self-checking bench for wallace_mul4_pipe against an arithmetic product model.
module tb_wallace_mul4_pipe;
    import mul_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    op_t   a;
    op_t   b;
    logic  out_valid;
    logic  out_ready;
    prod_t p;

    int errors = 0;
    int checks = 0;

    prod_t got_q[$];
    prod_t exp_q[$];

    always #5 clk = ~clk;

    wallace_mul4_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p)
    );

    function automatic prod_t ref_mul(input int x, input int y);
        return prod_t'(x * y);
    endfunction

    // Every accepted pair is owed exactly one product, in order.
    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
            if (out_valid && out_ready) got_q.push_back(p);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (p !== 8'h00) begin errors++; $display("FAIL reset_p: got %h want 00", p); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        checks++; if (p !== 8'h00) begin errors++; $display("FAIL post_reset_p: got %h want 00", p); end
        clear_queues();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 4'd9;
        b = 4'd6;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready0: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready%0d: got %b want 1", k, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid%0d: got %b want 0", k, out_valid); end
            step();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (p !== ref_mul(9, 6)) begin errors++; $display("FAIL single_p: got %h want %h", p, ref_mul(9, 6)); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b want 0", out_valid); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int pa[3] = '{15, 0, 1};
        int pb[3] = '{15, 13, 11};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = op_t'(pa[i]);
            b = op_t'(pb[i]);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", i, out_valid); end
            checks++; if (p !== ref_mul(pa[i], pb[i])) begin errors++; $display("FAIL b2b_p%0d: got %h want %h", i, p, ref_mul(pa[i], pb[i])); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
        idle(2);
    endtask

    task automatic test_sweep();
        int    perm[256];
        int    tmp;
        int    j;
        int    rows;
        logic  prev_v;
        prod_t prev_prod;
        prod_t want[$];
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        clear_queues();
        out_ready = 1'b1;
        prev_v    = 1'b0;
        prev_prod = '0;
        // The middle stage holds the pair taken one edge earlier.
        for (int i = 0; i < 258; i++) begin
            in_valid = (i < 256);
            if (i < 256) begin
                a = op_t'(perm[i] >> 4);
                b = op_t'(perm[i] & 15);
                want.push_back(ref_mul(perm[i] >> 4, perm[i] & 15));
            end
            step();
            checks++; if (dut.v1 !== prev_v) begin errors++; $display("FAIL sweep_v1 slot %0d: got %b want %b", i, dut.v1, prev_v); end
            if (prev_v) begin
                rows = int'(dut.sum_q) + int'(dut.carry_q);
                checks++; if (rows !== int'(prev_prod)) begin errors++; $display("FAIL sweep_rows slot %0d: got %0d want %0d", i, rows, prev_prod); end
            end
            prev_v    = (i < 256);
            prev_prod = (i < 256) ? ref_mul(perm[i] >> 4, perm[i] & 15) : 8'h00;
        end
        idle(4);
        checks++; if (got_q.size() !== 256) begin errors++; $display("FAIL sweep_count: got %0d want 256", got_q.size()); end
        for (int i = 0; i < 256 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL sweep_p %0d: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        int    pa[4] = '{3, 7, 12, 13};
        int    pb[4] = '{5, 7, 10, 13};
        prod_t held;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = op_t'(pa[i]);
            b = op_t'(pb[i]);
            step();
        end
        held      = ref_mul(pa[0], pb[0]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = op_t'(pa[3]);
        b = op_t'(pb[3]);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", k, out_valid); end
            checks++; if (p !== held) begin errors++; $display("FAIL bp_p%0d: got %h want %h", k, p, held); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        step();
        idle(5);
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== ref_mul(pa[i], pb[i])) begin errors++; $display("FAIL bp_order %0d: got %h want %h", i, got_q[i], ref_mul(pa[i], pb[i])); end
        end
    endtask

    task automatic test_reset_mid();
        int pa[3] = '{6, 8, 10};
        int pb[3] = '{7, 9, 11};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = op_t'(pa[i]);
            b = op_t'(pb[i]);
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        checks++; if (p !== 8'h00) begin errors++; $display("FAIL rmid_p: got %h want 00", p); end
        step();
        step();
        rst = 1'b0;
        clear_queues();
        in_valid = 1'b1;
        a = 4'd4;
        b = 4'd4;
        step();
        idle(5);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rmid_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== ref_mul(4, 4)) begin errors++; $display("FAIL rmid_p_new: got %h want %h", got_q[0], ref_mul(4, 4)); end
        end
    endtask

    task automatic test_sparse();
        logic  want_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        prod_t want_p[4];
        want_p[0] = ref_mul(2, 3);
        want_p[2] = ref_mul(5, 5);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'd2; b = 4'd3; step();
        in_valid = 1'b0; a = 4'd15; b = 4'd15; step();
        in_valid = 1'b1; a = 4'd5; b = 4'd5; step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== want_v[k]) begin errors++; $display("FAIL sparse_valid%0d: got %b want %b", k, out_valid, want_v[k]); end
            if (want_v[k]) begin
                checks++; if (p !== want_p[k]) begin errors++; $display("FAIL sparse_p%0d: got %h want %h", k, p, want_p[k]); end
            end
            step();
        end
    endtask

    task automatic test_random();
        logic  stall;
        prod_t held;
        clear_queues();
        stall = 1'b0;
        held  = '0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = op_t'($urandom);
            b         = op_t'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rand_in_ready %0d: got %b want %b", i, in_ready, !out_valid || out_ready); end
            stall = out_valid && !out_ready;
            held  = p;
            step();
            if (stall) begin
                checks++; if (out_valid !== 1'b1 || p !== held) begin errors++; $display("FAIL rand_hold %0d: got %b/%h want 1/%h", i, out_valid, p, held); end
            end
        end
        out_ready = 1'b1;
        idle(6);
        checks++; if (got_q.size() !== exp_q.size() || exp_q.size() == 0) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_p %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_sparse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
